// File: rtl/fifo_to_sdram_wr_controller.sv
// Packs a byte stream into 16-bit words for an SDRAM-bound FIFO and counts words per block.
// Optional build macro FIFO_TO_SDRAM_BYTE_SWAP_EN places the first byte in the upper half of the word.
module fifo_to_sdram_wr_controller #(
  parameter int WORDS_PER_BLOCK = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        fifo_full,
  input  logic        ovf_clr,
  output logic [15:0] fifo_data,
  output logic        fifo_wrreq,
  output logic        blk_rdy,
  output logic        overflow,
  output logic        byte_phase
);

  localparam logic [8:0] LAST_WORD = 9'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } phase_t;

  phase_t     state_p0;
  phase_t     state_nxt;
  logic [7:0] held_p0;
  logic [8:0] word_cnt_p0;
  logic       word_done;

  function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
`ifdef FIFO_TO_SDRAM_BYTE_SWAP_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  always_comb begin
    state_nxt = state_p0;
    word_done = 1'b0;
    if (byte_valid) begin
      case (state_p0)
        LOW:     state_nxt = HIGH;
        HIGH: begin
          state_nxt = LOW;
          word_done = 1'b1;
        end
        default: state_nxt = LOW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_p0 <= LOW;
    else        state_p0 <= state_nxt;
  end

  assign byte_phase = (state_p0 == HIGH);

  // Stage p0 -> p1: first byte is captured, completed word is issued one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_p0 <= 8'h00;
    end else if (byte_valid && state_p0 == LOW) begin
      held_p0 <= byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_data   <= 16'h0000;
      fifo_wrreq  <= 1'b0;
      blk_rdy     <= 1'b0;
      word_cnt_p0 <= 9'd0;
    end else begin
      fifo_wrreq <= 1'b0;
      blk_rdy    <= 1'b0;
      if (word_done && !fifo_full) begin
        fifo_wrreq  <= 1'b1;
        fifo_data   <= pack_word(held_p0, byte_in);
        blk_rdy     <= (word_cnt_p0 == LAST_WORD);
        word_cnt_p0 <= (word_cnt_p0 == LAST_WORD) ? 9'd0 : word_cnt_p0 + 9'd1;
      end
    end
  end

  // A drop in the same cycle as a clear wins so no lost word goes unreported
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      overflow <= 1'b0;
    else if (word_done && fifo_full) overflow <= 1'b1;
    else if (ovf_clr)                overflow <= 1'b0;
  end

endmodule
